// File: rtl/scope_display_ctrl.sv
// Waveform RAM scheduler and trace renderer for a VGA oscilloscope display.
// Reads one sample per column ahead of the beam and lends every other slot to the acquisition writer.
module scope_display_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_LAST   = 767,
  parameter int V_ACTIVE = 480,
  parameter int Y_OFFSET = 112
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pix_x,
  input  logic [8:0]        pix_y,
  input  logic              in_display,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              trig_valid,
  input  logic [ADDR_W-1:0] trig_addr,
  output logic              trig_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              pixel_on,
  output logic              grid_on
);
  localparam int         SMAX     = (1 << DATA_W) - 1;
  localparam logic [9:0] H_LAST_X = 10'(H_LAST);
  localparam logic [9:0] H_RD_END = 10'(H_ACTIVE - 1);
  localparam logic [8:0] V_FS     = 9'(V_ACTIVE);
  localparam logic [8:0] V_MID    = 9'(V_ACTIVE / 2);

  // Full-scale sample maps to Y_OFFSET; zero maps to the lowest trace row.
  function automatic logic [8:0] sample_row(input logic [DATA_W-1:0] s);
    return 9'(Y_OFFSET + SMAX) - 9'(s);
  endfunction

  logic [9:0]        x_q;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] sample_next_q, sample_next_d;
  logic [DATA_W-1:0] sample_cur_q, sample_cur_d;
  logic              ram_we_q, ram_we_d;
  logic              rd_pend_q, rd_pend_d;
  logic              pixel_on_q, pixel_on_d;
  logic              grid_on_q, grid_on_d;
  logic              x_chg, rd_slot, frame_start;

  always_comb begin
    x_chg       = (pix_x != x_q);
    // Column 0 of the next line is fetched while the beam sits on H_LAST.
    rd_slot     = x_chg && ((pix_x == H_LAST_X) || (pix_x < H_RD_END));
    frame_start = x_chg && (pix_x == 10'd0) && (pix_y == V_FS);
    wr_gnt      = !reset && !rd_slot && wr_req;
    trig_ack    = !reset && frame_start && trig_valid;

    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (rd_slot) begin
      ram_addr_d = (pix_x == H_LAST_X) ? rd_base_q
                                       : rd_base_q + ADDR_W'(pix_x) + ADDR_W'(1);
    end else if (wr_gnt) begin
      ram_addr_d  = wr_addr;
      ram_we_d    = 1'b1;
      ram_wdata_d = wr_data;
    end

    rd_pend_d     = rd_slot;
    sample_next_d = rd_pend_q ? ram_rdata : sample_next_q;
    sample_cur_d  = x_chg ? sample_next_q : sample_cur_q;
    rd_base_d     = trig_ack ? trig_addr : rd_base_q;

    pixel_on_d = in_display && (pix_y == sample_row(sample_cur_q));
    grid_on_d  = in_display && ((pix_x[5:0] == 6'd0) || (pix_y == V_MID));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      rd_base_q     <= '0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      rd_pend_q     <= 1'b0;
      sample_next_q <= '0;
      sample_cur_q  <= '0;
      pixel_on_q    <= 1'b0;
      grid_on_q     <= 1'b0;
    end else begin
      x_q           <= pix_x;
      rd_base_q     <= rd_base_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      rd_pend_q     <= rd_pend_d;
      sample_next_q <= sample_next_d;
      sample_cur_q  <= sample_cur_d;
      pixel_on_q    <= pixel_on_d;
      grid_on_q     <= grid_on_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign pixel_on  = pixel_on_q;
  assign grid_on   = grid_on_q;
endmodule

// File: tb/tb_scope_display_ctrl.sv
// Scoreboard bench for scope_display_ctrl: a behavioural model queues the expected registered
// outputs each cycle, and directed steps add fixed expectations for the key corner cases.
module tb_scope_display_ctrl;
  localparam int ADDR_W = 10, DATA_W = 8, H_ACTIVE = 640, H_LAST = 767;
  localparam int V_ACTIVE = 480, Y_OFFSET = 112;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [9:0]        pix_x = '0;
  logic [8:0]        pix_y = '0;
  logic              in_display = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_gnt;
  logic              trig_valid = 1'b0;
  logic [ADDR_W-1:0] trig_addr = '0;
  logic              trig_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              pixel_on;
  logic              grid_on;

  scope_display_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .H_LAST(H_LAST),
    .V_ACTIVE(V_ACTIVE), .Y_OFFSET(Y_OFFSET)
  ) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .in_display(in_display),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .trig_valid(trig_valid), .trig_addr(trig_addr), .trig_ack(trig_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pixel_on(pixel_on), .grid_on(grid_on)
  );

  always #10 clk = ~clk;

  // Waveform RAM: asynchronous read, synchronous write.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  typedef struct {
    int addr;
    int we;
    int wd;
    int pix;
    int grid;
  } exp_t;

  exp_t sbq[$];
  exp_t m_out = '{0, 0, 0, 0, 0};
  int   m_x = 0, m_base = 0, m_next = 0, m_cur = 0, m_pend = 0;
  int   n_chk = 0, n_bad = 0;
  int   deny = 0;
  bit   streak_on = 1'b0;
  logic last_gnt, last_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit r, input int x, input int y, input bit d, input bit wq,
                     input int wa, input int wd, input bit tv, input int ta);
    bit               chg, rs, fs;
    logic [DATA_W-1:0] rd;
    exp_t             e;
    reset = r; pix_x = 10'(x); pix_y = 9'(y); in_display = d;
    wr_req = wq; wr_addr = 10'(wa); wr_data = 8'(wd);
    trig_valid = tv; trig_addr = 10'(ta);
    #2;
    chg = (x != m_x);
    rs  = chg && (x == H_LAST || x < H_ACTIVE - 1);
    fs  = chg && x == 0 && y == V_ACTIVE;
    chk("wr_gnt", 32'(wr_gnt), 32'(!r && !rs && wq));
    chk("trig_ack", 32'(trig_ack), 32'(!r && fs && tv));
    last_gnt = wr_gnt;
    last_ack = trig_ack;
    if (streak_on) begin
      if (wq && !wr_gnt) deny++; else deny = 0;
      chk("starve", 32'(deny > 1), 32'(0));
    end
    rd = mem[m_out.addr];
    e = m_out;
    if (r) begin
      e = '{0, 0, 0, 0, 0};
      m_x = 0; m_base = 0; m_next = 0; m_cur = 0; m_pend = 0;
    end else begin
      e.we = 0;
      if (rs) e.addr = (x == H_LAST) ? m_base : (m_base + x + 1) % (1 << ADDR_W);
      else if (wq) begin e.addr = wa; e.we = 1; e.wd = wd; end
      e.pix  = int'(d && (y == Y_OFFSET + 255 - m_cur));
      e.grid = int'(d && ((x % 64) == 0 || y == V_ACTIVE / 2));
      if (chg) m_cur = m_next;
      if (m_pend != 0) m_next = int'(rd);
      m_pend = int'(rs);
      if (fs && tv) m_base = ta;
      m_x = x;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("ram_addr", 32'(ram_addr), e.addr);
    chk("ram_we", 32'(ram_we), e.we);
    chk("ram_wdata", 32'(ram_wdata), e.wd);
    chk("pixel_on", 32'(pixel_on), e.pix);
    chk("grid_on", 32'(grid_on), e.grid);
    m_out = e;
  endtask

  task automatic idle(input int x, input int y, input bit d);
    cyc(1'b0, x, y, d, 1'b0, 0, 0, 1'b0, 0);
  endtask

  int gcount;
  int rows[3] = '{112, 367, 239};
  int vals[3] = '{8'hFF, 8'h00, 8'h80};

  initial begin
    wr_req = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 0, 0, 1'b1, 1'b1, 12, 34, 1'b0, 0);
      chk("rst_gnt", 32'(last_gnt), 32'(0));
      chk("rst_we", 32'(ram_we), 32'(0));
      chk("rst_pix", 32'(pixel_on), 32'(0));
    end
    cyc(1'b0, 0, 0, 1'b1, 1'b1, 12, 34, 1'b0, 0);
    chk("gnt_after_rst", 32'(last_gnt), 32'(1));
    chk("we_after_rst", 32'(ram_we), 32'(1));
    chk("addr_after_rst", 32'(ram_addr), 32'(12));

    // Adopt base 0x3F0, then step 4 -> 5 in the active area.
    idle(700, 480, 1'b0);
    cyc(1'b0, 0, 480, 1'b0, 1'b0, 0, 0, 1'b1, 'h3F0);
    chk("ack_3f0", 32'(last_ack), 32'(1));
    idle(4, 0, 1'b1);
    idle(4, 0, 1'b1);
    cyc(1'b0, 5, 0, 1'b1, 1'b1, 40, 7, 1'b0, 0);
    chk("slot_gnt", 32'(last_gnt), 32'(0));
    chk("slot_addr", 32'(ram_addr), 32'h3F6);
    chk("slot_we", 32'(ram_we), 32'(0));

    // Address wrap with base 0x3FF.
    idle(767, 480, 1'b0);
    cyc(1'b0, 0, 480, 1'b0, 1'b0, 0, 0, 1'b1, 'h3FF);
    chk("ack_3ff", 32'(last_ack), 32'(1));
    idle(767, 0, 1'b0);
    chk("col0_3ff", 32'(ram_addr), 32'h3FF);
    idle(0, 0, 1'b1);
    chk("wrap_addr", 32'(ram_addr), 32'h000);

    // Mid-frame trigger is ignored; frame boundary adopts it.
    cyc(1'b0, 100, 100, 1'b1, 1'b0, 0, 0, 1'b1, 'h155);
    chk("ack_mid", 32'(last_ack), 32'(0));
    idle(767, 100, 1'b0);
    chk("base_kept", 32'(ram_addr), 32'h3FF);
    idle(700, 480, 1'b0);
    cyc(1'b0, 0, 480, 1'b0, 1'b0, 0, 0, 1'b1, 'h155);
    chk("ack_155", 32'(last_ack), 32'(1));
    idle(767, 0, 1'b0);
    chk("col0_155", 32'(ram_addr), 32'h155);

    // Writer streams through an active line: granted once per column.
    streak_on = 1'b1;
    gcount = 0;
    for (int c = 0; c <= 30; c++) begin
      for (int k = 0; k < 2; k++) begin
        cyc(1'b0, c, 10, 1'b1, 1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 1'b0, 0);
        gcount += int'(last_gnt);
      end
    end
    streak_on = 1'b0;
    chk("line_grants", 32'(gcount), 32'(31));

    // Trace rows for full-scale, zero and mid-scale samples.
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 30, 10, 1'b0, 1'b1, 'h155 + 10 + k, vals[k], 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      idle(200, 0, 1'b1);
      idle(9 + k, 0, 1'b1);
      idle(9 + k, 0, 1'b1);
      idle(10 + k, 0, 1'b1);
      idle(10 + k, rows[k] - 1, 1'b1);
      chk("row_below", 32'(pixel_on), 32'(0));
      idle(10 + k, rows[k], 1'b1);
      chk("row_hit", 32'(pixel_on), 32'(1));
      idle(10 + k, rows[k] + 1, 1'b1);
      chk("row_above", 32'(pixel_on), 32'(0));
    end

    // Graticule and blanking.
    idle(0, 240, 1'b1);
    chk("grid_on_mid", 32'(grid_on), 32'(1));
    idle(65, 479, 1'b1);
    chk("grid_off", 32'(grid_on), 32'(0));
    idle(64, 240, 1'b0);
    chk("blank_grid", 32'(grid_on), 32'(0));
    chk("blank_pix", 32'(pixel_on), 32'(0));

    // Reset with a read pending and the writer waiting.
    idle(300, 0, 1'b1);
    cyc(1'b1, 300, 0, 1'b1, 1'b1, 77, 88, 1'b0, 0);
    chk("mid_rst_we", 32'(ram_we), 32'(0));
    cyc(1'b0, 5, 0, 1'b1, 1'b1, 77, 88, 1'b0, 0);
    chk("post_rst_slot", 32'(last_gnt), 32'(0));
    chk("post_rst_base", 32'(ram_addr), 32'(6));
    cyc(1'b0, 5, 0, 1'b1, 1'b1, 77, 88, 1'b0, 0);
    chk("post_rst_gnt", 32'(last_gnt), 32'(1));
    chk("post_rst_waddr", 32'(ram_addr), 32'(77));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/scope_display_ctrl.md
Name: scope_display_ctrl

Overview:
- Schedules the single-port waveform RAM between the acquisition writer and the VGA trace renderer.
- Fetches one sample per displayed column, one column ahead of the beam, from pix_x/pix_y/in_display produced by the VGA sync generator.
- Converts the current column's sample into a lit pixel, plus a fixed graticule.
- Latches a new frame base address (trigger point) only at frame boundaries, so a frame never tears.

Parameters:
- ADDR_W, 10, waveform RAM address width; all address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, sample width.
- H_ACTIVE, 640, visible columns.
- H_LAST, 767, final pix_x value before wrap to 0.
- V_ACTIVE, 480, visible lines.
- Y_OFFSET, 112, screen row corresponding to sample value 2^DATA_W-1.

Ports:
- clk  in  1  system clock (50 MHz); pix_x advances every 2 clk.
- reset  in  1  synchronous, active-high.
- pix_x  in  10  column counter from the sync generator.
- pix_y  in  9  line counter from the sync generator.
- in_display  in  1  active-area flag from the sync generator.
- wr_req  in  1  writer requests a RAM write; held until granted.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  combinational; write accepted this cycle.
- trig_valid  in  1  new frame base is offered.
- trig_addr  in  ADDR_W  offered frame base.
- trig_ack  out  1  one-cycle pulse; base adopted.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 clk after ram_addr.
- pixel_on  out  1  registered trace pixel.
- grid_on  out  1  registered graticule pixel.

Behaviour:
- Reset values:
  - All outputs 0.
  - rd_base=0, sample_next=0, sample_cur=0, x_q=0, rd_pend=0.
- Column-change detect:
  - x_q <= pix_x every cycle.
  - x_chg = (pix_x != x_q).
- Slot arbitration, evaluated every cycle, display has priority:
  - Display read slot when x_chg and (pix_x==H_LAST or pix_x<H_ACTIVE-1).
    - Read address is rd_base when pix_x==H_LAST, else rd_base+pix_x+1.
    - Next cycle: ram_we=0, rd_pend=1.
    - wr_gnt=0.
  - Otherwise, if wr_req=1:
    - wr_gnt=1.
    - Next cycle: ram_addr=wr_addr, ram_we=1, ram_wdata=wr_data.
  - Otherwise ram_we=0; ram_addr holds its value.
- Bandwidth guarantee: the writer is granted at least every other cycle, and is never starved for more than 1 consecutive cycle.
- Read capture:
  - The cycle after rd_pend=1, sample_next <= ram_rdata and rd_pend clears.
  - Latency: 2 clk from slot decision to sample_next, which is within the 2-clk column period.
- Column commit: on x_chg, sample_cur <= sample_next. Column c therefore displays the sample at rd_base+c.
- Frame boundary: frame_start = x_chg and pix_x==0 and pix_y==V_ACTIVE.
  - At frame_start with trig_valid=1: rd_base <= trig_addr and trig_ack=1 for that cycle.
  - trig_valid at any other time is ignored: no ack, and rd_base is unchanged.
- Pixel generation, registered at 1 clk latency:
  - row = Y_OFFSET + (2^DATA_W-1) - sample_cur, 9-bit unsigned with no overflow (max 367 at default parameters).
  - pixel_on <= in_display and (pix_y == row).
  - grid_on <= in_display and (pix_x[5:0]==0 or pix_y==V_ACTIVE/2).
- Boundaries:
  - x_chg with pix_x==H_ACTIVE-1: no read is issued; the writer may use the slot.
  - x_chg with pix_x between H_ACTIVE and H_LAST-1: writer slots only.
  - Address rd_base+pix_x+1 wraps at 2^ADDR_W.
  - Write and read to the same address in adjacent cycles: the RAM's ordering governs; no forwarding is performed.
- Reset mid-operation:
  - Any pending read is dropped and rd_base returns to 0.
  - A request with wr_req held through reset is granted on the first non-read-slot cycle after reset deasserts.

Test Plan:
- Reset held 4 clk with wr_req=1 → wr_gnt=0, ram_we=0, pixel_on=0 throughout; after release, first non-read-slot cycle gives wr_gnt=1 and ram_we=1 on the next cycle.
- pix_x stepping 4→5 with rd_base=0x3F0 → ram_addr=0x3F6, ram_we=0, wr_gnt=0 in that slot; pix_x=0x3FF+... wrap case rd_base=0x3FF, pix_x=0 read → ram_addr=0x000.
- Continuous wr_req during active line → wr_gnt high exactly on cycles without x_chg (1 of every 2); no two consecutive denials.
- RAM returns 0xFF for the column under test → pixel_on=1 only on line 112; 0x00 → line 367; 0x80 → line 239.
- trig_valid=1, trig_addr=0x155 at mid-frame → no trig_ack, rd_base unchanged; at pix_y=480, pix_x=0 change → trig_ack pulse, and column 0 of the next frame reads 0x155.
- pix_x=0, pix_y=240 inside the active area → grid_on=1; pix_y=479, pix_x=65 → grid_on=0; with in_display=0 both outputs are 0.
